// File: rtl/hier_fanout_node.sv
// hier_fanout_node: tree node that buffers parent commands in a small FIFO and
// dispatches them to NUM_CHILDREN children, either unicast (round-robin) or
// broadcast (complete once every child has accepted).
// Optional watchdog: define HIER_NODE_TIMEOUT_EN to abort commands that stall
// for TIMEOUT_CYC cycles.
`timescale 1ns/1ps
module hier_fanout_node #(
    parameter int unsigned NUM_CHILDREN = 10,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [DATA_W-1:0]       up_data,
    input  logic                    up_bcast,
    output logic [NUM_CHILDREN-1:0] dn_valid,
    input  logic [NUM_CHILDREN-1:0] dn_ready,
    output logic [DATA_W-1:0]       dn_data,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [15:0]             sent_count,
    output logic                    err_timeout,
    output logic [NUM_CHILDREN-1:0] err_mask
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(NUM_CHILDREN);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [PW-1:0] LAST_PTR = PW'(NUM_CHILDREN - 1);

    if (NUM_CHILDREN < 2 || NUM_CHILDREN > 32 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("hier_fanout_node: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_UNI, S_BCAST} state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W:0]       r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_cnt;
    logic [AW:0]           w_cnt_nxt;
    logic                  r_up_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [DATA_W:0]       w_head;

    // dispatch state
    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_ptr;
    logic [NUM_CHILDREN-1:0] r_pending;
    logic [NUM_CHILDREN-1:0] w_pend_left;
    logic [NUM_CHILDREN-1:0] w_ptr_onehot;
    logic [DATA_W-1:0]     r_data;
    logic                  r_done;
    logic [15:0]           r_sent;
    logic                  w_complete;
    logic                  w_abort;

    assign w_push       = up_valid && r_up_ready;
    assign w_empty      = (r_cnt == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_ptr_onehot = NUM_CHILDREN'(1) << r_ptr;

    // occupancy after this cycle's push/pop
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // FIFO payload array; contents need no reset because r_cnt gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {up_bcast, up_data};
        end
    end

    // FIFO pointers, count and registered not-full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_up_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt      <= w_cnt_nxt;
            r_up_ready <= (w_cnt_nxt != FULL_CNT);
        end
    end

    // completion detection for the command in flight
    always_comb begin
        w_complete  = 1'b0;
        w_pend_left = r_pending & ~dn_ready;
        case (r_state)
            S_UNI:   w_complete = dn_ready[r_ptr];
            S_BCAST: w_complete = (w_pend_left == '0);
            default: w_complete = 1'b0;
        endcase
    end

    // next state and FIFO pop; a finishing command hands over without a bubble
    always_comb begin
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        if (r_state == S_IDLE || w_complete || w_abort) begin
            if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = w_head[DATA_W] ? S_BCAST : S_UNI;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // dispatch registers: state, payload, pending mask, rr pointer, counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_pending <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_sent    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_complete;
            if (w_complete && r_sent != 16'hFFFF) begin
                r_sent <= r_sent + 1'b1;
            end
            if ((w_complete || w_abort) && r_state == S_UNI) begin
                r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
            end
            if (r_state == S_BCAST) begin
                r_pending <= w_pend_left;
            end
            if (w_pop) begin
                r_data    <= w_head[DATA_W-1:0];
                r_pending <= '1;
            end
        end
    end

    // child valids are decoded from state so reset drops them immediately
    always_comb begin
        dn_valid = '0;
        case (r_state)
            S_UNI:   dn_valid = w_ptr_onehot;
            S_BCAST: dn_valid = r_pending;
            default: dn_valid = '0;
        endcase
    end

`ifdef HIER_NODE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0]           r_tmo;
    logic                    r_err;
    logic [NUM_CHILDREN-1:0] r_err_mask;

    assign w_abort = (r_state != S_IDLE) && !w_complete && (r_tmo == TMO_LAST);

    // watchdog: cycles spent on the current command, abort capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo      <= '0;
            r_err      <= 1'b0;
            r_err_mask <= '0;
        end else begin
            r_err <= w_abort;
            if (w_pop) begin
                r_tmo <= '0;
            end else if (r_state != S_IDLE) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_abort) begin
                r_err_mask <= (r_state == S_UNI) ? w_ptr_onehot : w_pend_left;
            end
        end
    end

    assign err_timeout = r_err;
    assign err_mask    = r_err_mask;
`else
    assign w_abort     = 1'b0;
    assign err_timeout = 1'b0;
    assign err_mask    = '0;
`endif

    assign up_ready   = r_up_ready;
    assign dn_data    = r_data;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign done_pulse = r_done;
    assign sent_count = r_sent;

endmodule

// File: tb/tb_hier_fanout_node.sv
// Testbench for hier_fanout_node: stimulus queues expected deliveries per
// command; a negedge monitor matches them against child handshakes.
`timescale 1ns/1ps
module tb_hier_fanout_node;

    localparam int unsigned NC = 10;
    localparam int unsigned DW = 8;
    localparam logic [NC-1:0] ALL = '1;

    logic          clk;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [DW-1:0] up_data;
    logic          up_bcast;
    logic [NC-1:0] dn_valid;
    logic [NC-1:0] dn_ready;
    logic [DW-1:0] dn_data;
    logic          busy;
    logic          done_pulse;
    logic [15:0]   sent_count;
    logic          err_timeout;
    logic [NC-1:0] err_mask;

    logic [NC-1:0] rdy_val;
    logic [NC-1:0] rdy_rand;
    logic          rdy_rand_en;

    typedef struct {
        logic          b;
        int unsigned   child;
        logic [DW-1:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rr     = 0;
    int unsigned n_done = 0;
    logic        mon_en = 1'b1;

    // monitor state
    logic          exp_done  = 1'b0;
    logic [15:0]   exp_sent  = '0;
    logic [NC-1:0] bc_rem    = '0;
    logic          bc_active = 1'b0;
    logic [NC-1:0] hs;
    logic          fin;
    exp_t          e_m;

    hier_fanout_node #(
        .NUM_CHILDREN(NC),
        .DATA_W      (DW),
        .DEPTH       (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_bcast   (up_bcast),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .dn_data    (dn_data),
        .busy       (busy),
        .done_pulse (done_pulse),
        .sent_count (sent_count),
        .err_timeout(err_timeout),
        .err_mask   (err_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dn_ready = rdy_rand_en ? rdy_rand : rdy_val;

    always @(posedge clk) begin
        #1;
        rdy_rand = NC'($urandom);
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done  = 1'b0;
            exp_sent  = '0;
            bc_active = 1'b0;
            bc_rem    = '0;
        end else if (mon_en) begin
            check("done_pulse", {31'd0, done_pulse}, {31'd0, exp_done});
            check("sent_count", {16'd0, sent_count}, {16'd0, exp_sent});
`ifndef HIER_NODE_TIMEOUT_EN
            check("err_idle", {21'd0, err_timeout, err_mask}, 32'd0);
`endif
            exp_done = 1'b0;
            fin      = 1'b0;
            hs       = dn_valid & dn_ready;
            if (dn_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("dn_valid_spurious", {22'd0, dn_valid}, 32'd0);
                end else begin
                    e_m = exp_q[0];
                    check("dn_data", {24'd0, dn_data}, {24'd0, e_m.d});
                    if (!e_m.b) begin
                        check("uni_target", {22'd0, dn_valid}, {22'd0, NC'(1) << e_m.child});
                        fin = dn_valid[e_m.child] && dn_ready[e_m.child];
                    end else begin
                        if (!bc_active) begin
                            bc_active = 1'b1;
                            bc_rem    = ALL;
                        end
                        check("bcast_mask", {22'd0, dn_valid}, {22'd0, bc_rem});
                        bc_rem = bc_rem & ~hs;
                        fin    = (bc_rem == '0);
                    end
                    if (fin) begin
                        void'(exp_q.pop_front());
                        bc_active = 1'b0;
                        exp_done  = 1'b1;
                        n_done++;
                        if (exp_sent != 16'hFFFF) exp_sent = exp_sent + 16'd1;
                    end
                end
            end
        end
    end

    // call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic push(input logic b, input logic [DW-1:0] d);
        int unsigned n;
        exp_t        e;
        n = 0;
        up_valid = 1'b1;
        up_bcast = b;
        up_data  = d;
        @(negedge clk);
        while (!up_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", {31'd0, up_ready}, 32'd1);
        if (up_ready) begin
            e.b     = b;
            e.child = b ? 0 : rr;
            e.d     = d;
            if (mon_en) exp_q.push_back(e);
            if (!b) rr = (rr == NC - 1) ? 0 : rr + 1;
        end
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, {31'd0, (n < 5000)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dn_valid == '0 && n < 50);
        check({name, "_valid_seen"}, {31'd0, (dn_valid != '0)}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rr  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #(10_000_000);
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wn;
        int unsigned base;
        logic        saw;
        rst = 1'b1;
        up_valid = 1'b0;
        up_bcast = 1'b0;
        up_data = '0;
        rdy_val = '0;
        rdy_rand_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset values
        @(negedge clk);
        check("rst_up_ready", {31'd0, up_ready}, 32'd1);
        check("rst_dn_valid", {22'd0, dn_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done_pulse}, 32'd0);
        check("rst_sent", {16'd0, sent_count}, 32'd0);
        check("rst_dn_data", {24'd0, dn_data}, 32'd0);
        check("rst_err", {21'd0, err_timeout, err_mask}, 32'd0);
        @(posedge clk);
        #1;

        // twelve unicasts, all children ready; first-command latency
        rdy_val = ALL;
        push(1'b0, 8'h00);
        @(negedge clk);
        check("lat_t1", {22'd0, dn_valid}, 32'd0);
        @(negedge clk);
        check("lat_t2", {22'd0, dn_valid}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 1; i < 12; i++) push(1'b0, DW'(i));
        drain("t1");
        check("t1_sent", {16'd0, sent_count}, 32'd12);
        check("t1_done", n_done, 32'd12);

        // broadcast, children accept one per cycle from 9 down to 0
        rdy_val = NC'(1) << (NC - 1);
        push(1'b1, 8'hA5);
        wait_valid("t2");
        for (int i = NC - 1; i >= 0; i--) begin
            check("t2_shrink", {22'd0, dn_valid}, (32'd1 << (i + 1)) - 32'd1);
            @(posedge clk);
            #1;
            rdy_val = (i > 0) ? (NC'(1) << (i - 1)) : '0;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdy_val = ALL;
        push(1'b0, 8'h77);
        drain("t2");
        check("t2_sent", {16'd0, sent_count}, 32'd14);

        // back-pressure: one in flight plus a full FIFO, then release
        rdy_val = '0;
        for (int i = 0; i < 5; i++) push(1'b0, DW'(8'h30 + i));
        @(negedge clk);
        check("t3_full", {31'd0, up_ready}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        rdy_val = ALL;
        wn = 0;
        do begin
            @(negedge clk);
            wn++;
        end while (!done_pulse && wn < 20);
        check("t3_first_done", {31'd0, done_pulse}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_b2b", {31'd0, done_pulse}, 32'd1);
        end
        @(posedge clk);
        #1;
        drain("t3");

        // randomized mix under random child readiness
        rdy_rand_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            push(($urandom_range(0, 3) == 0), DW'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain("rand");
        rdy_rand_en = 1'b0;

        // reset during a broadcast with three children pending and two queued
        rdy_val = '0;
        push(1'b1, 8'hC3);
        push(1'b0, 8'h01);
        push(1'b0, 8'h02);
        wait_valid("t4");
        @(posedge clk);
        #1;
        rdy_val = ALL & ~NC'(7);
        @(negedge clk);
        @(posedge clk);
        #1;
        rdy_val = '0;
        @(negedge clk);
        check("t4_pending", {22'd0, dn_valid}, 32'd7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rr  = 0;
        @(posedge clk);
        @(negedge clk);
        check("t4_dn_valid", {22'd0, dn_valid}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_sent", {16'd0, sent_count}, 32'd0);
        check("t4_up_ready", {31'd0, up_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_val = ALL;
        push(1'b0, 8'h44);
        drain("t4");
        check("t4_after_sent", {16'd0, sent_count}, 32'd1);

        // counter saturation: 0xFFFE completions plus three more
        do_reset();
        rdy_val = ALL;
        base = n_done;
        for (int unsigned i = 0; i < 32'd65537; i++) push(1'b0, DW'(i));
        drain("t5");
        check("t5_sat", {16'd0, sent_count}, 32'h0000FFFF);
        check("t5_done", n_done - base, 32'd65537);

`ifdef HIER_NODE_TIMEOUT_EN
        // watchdog: children 3 and 7 never accept the broadcast
        do_reset();
        mon_en = 1'b0;
        rdy_val = ALL & ~(NC'(1) << 3) & ~(NC'(1) << 7);
        push(1'b1, 8'h5A);
        push(1'b0, 8'h33);
        wn  = 0;
        saw = 1'b0;
        do begin
            @(negedge clk);
            wn++;
            if (done_pulse) saw = 1'b1;
        end while (!err_timeout && wn < 200);
        check("tmo_cycles", wn, 32'd64);
        check("tmo_mask", {22'd0, err_mask}, 32'b0010001000);
        check("tmo_no_done", {31'd0, saw}, 32'd0);
        wn = 0;
        do begin
            @(negedge clk);
            wn++;
        end while (!done_pulse && wn < 20);
        check("tmo_next_done", {31'd0, done_pulse}, 32'd1);
        check("tmo_next_data", {24'd0, dn_data}, 32'h33);
        check("tmo_sent", {16'd0, sent_count}, 32'd1);
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
